// File: rtl/wb_burst_master.sv
// ---------------------------------------------------------------------------
// wb_burst_master
//   Wishbone B4 pipelined initiator. Takes one command at a time, either a
//   single beat or a BURST_BEATS-beat incrementing burst, and issues it on the
//   bus while honouring stall_i. Caps the number of accepted-but-unacked beats
//   at MAX_OUTSTANDING. Returns read data in order and pulses done_o once every
//   beat of the command has been acked.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_addr_i                 start byte address ([1:0] ignored)
//   cmd_we_i                   1 = write, 0 = read
//   cmd_burst_i                1 = BURST_BEATS beats, 0 = single beat
//   cmd_sel_i                  byte selects, applied to every beat
//   wr_data_i/valid_i/ready_o  write beat stream (consumed on bus accept)
//   rd_data_o/valid_o/last_o   read beat stream (no backpressure)
//   done_o                     one-cycle pulse after the final ack
//   err_o                      sticky: ack_i seen with nothing outstanding
//   addr_o .. we_o             Wishbone master outputs
//   data_i, ack_i, stall_i     Wishbone slave responses
// ---------------------------------------------------------------------------
module wb_burst_master #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BURST_BEATS     = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // command
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_addr_i,
    input  logic        cmd_we_i,
    input  logic        cmd_burst_i,
    input  logic [3:0]  cmd_sel_i,
    // write stream
    input  logic [31:0] wr_data_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    // read stream / status
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        rd_last_o,
    output logic        done_o,
    output logic        err_o,
    // wishbone
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [2:0]  cti_o,
    output logic        we_o,
    input  logic [31:0] data_i,
    input  logic        ack_i,
    input  logic        stall_i
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(BURST_BEATS + 1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t          state;
    logic [31:0]     addr_q;
    logic            we_q;
    logic            burst_q;
    logic [3:0]      sel_q;
    logic [BW-1:0]   beats_q;
    logic [BW-1:0]   issued_q;
    logic [BW-1:0]   acked_q;
    logic [OW-1:0]   outst_q;
    logic            cyc_q;
    logic            ready_q;
    logic            done_q;
    logic            err_q;

    logic            stb;
    logic            accept;
    logic            ack_ok;
    logic            last_issue;
    logic            last_ack;

    // stb only depends on registered state plus wr_valid_i. While stalled the
    // outstanding count can only fall and the write source must hold its beat,
    // so stb and the presented beat stay put until the slave takes it.
    assign stb        = (state == ISSUE) && (outst_q < OW'(MAX_OUTSTANDING))
                        && (!we_q || wr_valid_i);
    assign accept     = stb && !stall_i;
    // A beat accepted this cycle may be acked in the same cycle by a
    // zero-latency slave, so it counts as outstanding for ack qualification.
    assign ack_ok     = ack_i && ((outst_q != '0) || accept);
    assign last_issue = (issued_q == beats_q - BW'(1));
    assign last_ack   = ack_ok && (acked_q == beats_q - BW'(1));

    // Bus outputs
    assign cyc_o  = cyc_q;
    assign stb_o  = stb;
    assign addr_o = cyc_q ? addr_q : 32'h0;
    assign sel_o  = cyc_q ? sel_q : 4'h0;
    assign we_o   = cyc_q && we_q;
    assign cti_o  = !cyc_q   ? CTI_CLASSIC :
                    !burst_q ? CTI_CLASSIC :
                    last_issue ? CTI_END : CTI_INCR;
    assign data_o = (stb && we_q) ? wr_data_i : 32'h0;

    // Core-side outputs
    assign cmd_ready_o = ready_q;
    assign wr_ready_o  = accept && we_q;
    assign rd_valid_o  = ack_ok && !we_q;
    assign rd_data_o   = rd_valid_o ? data_i : 32'h0;
    assign rd_last_o   = rd_valid_o && last_ack;
    assign done_o      = done_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            burst_q  <= 1'b0;
            sel_q    <= '0;
            beats_q  <= '0;
            issued_q <= '0;
            acked_q  <= '0;
            outst_q  <= '0;
            cyc_q    <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ack_i && !ack_ok)
                err_q <= 1'b1;

            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid_i && ready_q) begin
                        addr_q   <= {cmd_addr_i[31:2], 2'b00};
                        we_q     <= cmd_we_i;
                        burst_q  <= cmd_burst_i;
                        sel_q    <= cmd_sel_i;
                        beats_q  <= cmd_burst_i ? BW'(BURST_BEATS) : BW'(1);
                        issued_q <= '0;
                        acked_q  <= '0;
                        outst_q  <= '0;
                        cyc_q    <= 1'b1;
                        ready_q  <= 1'b0;
                        state    <= ISSUE;
                    end
                end

                ISSUE, DRAIN: begin
                    // accept and ack in the same cycle cancel out
                    case ({accept, ack_ok})
                        2'b10:   outst_q <= outst_q + OW'(1);
                        2'b01:   outst_q <= outst_q - OW'(1);
                        default: outst_q <= outst_q;
                    endcase
                    if (ack_ok)
                        acked_q <= acked_q + BW'(1);
                    if (accept) begin
                        addr_q   <= addr_q + 32'd4;
                        issued_q <= issued_q + BW'(1);
                    end

                    // last_ack in ISSUE only happens when the final beat is
                    // accepted and acked in the same cycle.
                    if (last_ack) begin
                        state   <= IDLE;
                        cyc_q   <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (state == ISSUE && accept && last_issue) begin
                        state <= DRAIN;
                    end
                end

                default: begin
                    state <= IDLE;
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Synthesizable Wishbone B4 pipelined initiator: the master end of the pipelined bus used by our memory/peripheral slaves. Accepts one command at a time (single beat or 8-beat incrementing burst) and issues it on the bus, honouring stall_i. Tracks outstanding acks up to a limit, streams read data back in order, and signals command completion. Sits between core-side fetch/LSU/DMA logic and the Wishbone fabric.

Parameters:
MAX_OUTSTANDING, 4, max beats accepted by slave but not yet acked (1..15)
BURST_BEATS, 8, beats per burst command (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&ready
cmd_addr_i  in  32  start byte address; [1:0] ignored
cmd_we_i  in  1  1=write, 0=read
cmd_burst_i  in  1  1=BURST_BEATS beats, 0=single beat
cmd_sel_i  in  4  byte selects, applied to every beat
wr_data_i  in  32  write beat data
wr_valid_i  in  1  write beat available
wr_ready_o  out  1  write beat consumed
rd_data_o  out  32  read beat data
rd_valid_o  out  1  read beat valid (no backpressure)
rd_last_o  out  1  final read beat of command
done_o  out  1  one-cycle pulse: command fully acked
err_o  out  1  sticky: ack_i with zero outstanding
addr_o  out  32  bus address, [1:0]=00
data_o  out  32  bus write data
sel_o  out  4  bus byte selects
cyc_o  out  1  bus cycle
stb_o  out  1  bus strobe
cti_o  out  3  cycle type
we_o  out  1  bus write enable
data_i  in  32  bus read data
ack_i  in  1  bus ack
stall_i  in  1  bus stall

Behaviour:
- Reset (async, rst_ni=0): all outputs 0; state IDLE; counters 0; err_o 0. Asserting reset mid-command drops cyc_o/stb_o immediately; pending acks are forgotten.
- States IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready_o=1, cyc_o=0, stb_o=0. On cmd_valid_i: latch addr({addr[31:2],2'b00}), we, sel, beats=burst?BURST_BEATS:1; next ISSUE.
- ISSUE: cyc_o=1. stb_o=1 iff outstanding<MAX_OUTSTANDING and (read or wr_valid_i). Beat accepted when stb_o&!stall_i.
- While stb_o&stall_i: addr_o, data_o, sel_o, cti_o, we_o held stable; nothing counted.
- Writes: data_o=wr_data_i while stb_o; wr_ready_o=stb_o&!stall_i (combinational). Reads: data_o=0, wr_ready_o=0.
- On accept: addr += 4 (32-bit wrap, no burst wrap), issued++, outstanding++.
- cti_o: single 3'b000; burst 3'b010 on beats 0..BURST_BEATS-2, 3'b111 on last beat.
- Accept of last beat -> DRAIN (stb_o=0 next cycle).
- ack_i with outstanding>0: outstanding--. Same-cycle accept and ack: outstanding unchanged. Counter width clog2(MAX_OUTSTANDING+1).
- Read ack: rd_valid_o=1, rd_data_o=data_i same cycle (combinational); rd_last_o=1 on ack completing final beat.
- Writes: rd_valid_o=0.
- DRAIN: cyc_o=1, stb_o=0 until last ack. Cycle after last ack: done_o=1 for one cycle, state IDLE, cyc_o=0.
- Single beat acked in its accept cycle (zero-latency slave) is legal; counters handle it.
- ack_i when outstanding==0 (including in IDLE): ignored, err_o set; cleared only by reset.
- No new command accepted until done_o; cmd_ready_o=0 outside IDLE.

Test Plan:
- Single write 0x1000, sel F, data 0xDEADBEEF, no stall, ack 1 cycle later -> one stb cycle, addr_o=0x1000, cti_o=000, done_o pulses cycle after ack, cyc_o low next.
- Read burst 0x2000, slave returns 0..7 with random stall/ack delay -> addr_o 0x2000..0x201C each accepted once in order, cti 010 x7 then 111, 8 rd_valid_o with data 0..7, rd_last_o only on 8th.
- MAX_OUTSTANDING=4, slave withholds acks -> stb_o drops after 4 accepts; one ack -> exactly one more beat issued.
- stall_i high 5 cycles on beat 2 of a write burst -> addr/data/sel/cti stable, wr_ready_o=0 throughout, beat counted once.
- Write burst with wr_valid_i low on beats 3 and 5 -> stb_o low those cycles, 8 beats total, data matches stream.
- rst_ni low mid-burst -> cyc_o/stb_o 0 immediately, cmd_ready_o=1 after release; stray ack_i in IDLE -> err_o=1 and sticky.
